// File: rtl/rggen_bit_field_rw_action_if.sv
// Register-to-bit-field access bundle: the register drives the access strobes and masks,
// and the bit field returns its stored value.
interface rggen_bit_field_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );

  modport slave (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );

  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_rw_action.sv
// Generic single bit-field engine: parametrised software read/write actions merged with
// per-bit hardware set/clear, plus registered access triggers and a value-change flag.
module rggen_bit_field_rw_action #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int unsigned      READ_ACTION   = 0,
  parameter int unsigned      WRITE_ACTION  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic [WIDTH-1:0]     i_hw_set,
  input  logic [WIDTH-1:0]     i_hw_clear,
  output logic [WIDTH-1:0]     o_value,
  output logic [WIDTH-1:0]     o_write_trigger,
  output logic                 o_read_trigger,
  output logic                 o_changed
);

  if (READ_ACTION > 2) begin : g_bad_read_action
    $error("rggen_bit_field_rw_action: READ_ACTION must be 0, 1 or 2");
  end
  if (WRITE_ACTION > 7) begin : g_bad_write_action
    $error("rggen_bit_field_rw_action: WRITE_ACTION must be in 0..7");
  end
  if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
    $error("rggen_bit_field_rw_action: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] write_trigger_q, write_trigger_d;
  logic             read_trigger_q, read_trigger_d;
  logic             changed_q, changed_d;

  logic             read_access;
  logic             write_access;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sw_next;

  // A non-zero read mask marks the access as a read regardless of write_mask.
  assign read_access  = bit_field_if.valid && (bit_field_if.read_mask != '0);
  assign write_access = bit_field_if.valid && (bit_field_if.read_mask == '0);
  assign wmask        = bit_field_if.write_mask;
  assign wdata        = bit_field_if.write_data;

  always_comb begin
    sw_next = value_q;
    if (read_access) begin
      if (READ_ACTION == 1) begin
        sw_next = '0;
      end else if (READ_ACTION == 2) begin
        sw_next = '1;
      end
    end else if (write_access) begin
      case (WRITE_ACTION)
        0:       sw_next = (wdata & wmask) | (value_q & ~wmask);
        1:       sw_next = value_q & ~(wdata & wmask);
        2:       sw_next = value_q | (wdata & wmask);
        3:       sw_next = value_q & ~(~wdata & wmask);
        4:       sw_next = value_q | (~wdata & wmask);
        5:       sw_next = value_q & ~wmask;
        6:       sw_next = value_q | wmask;
        default: sw_next = value_q;
      endcase
    end
  end

  // Hardware wins over software so sticky events survive a simultaneous W1C or read-clear.
  always_comb begin
    value_d         = (sw_next & ~i_hw_clear) | i_hw_set;
    changed_d       = (value_d != value_q);
    write_trigger_d = write_access ? wmask : '0;
    read_trigger_d  = read_access;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q         <= INITIAL_VALUE;
      write_trigger_q <= '0;
      read_trigger_q  <= 1'b0;
      changed_q       <= 1'b0;
    end else begin
      value_q         <= value_d;
      write_trigger_q <= write_trigger_d;
      read_trigger_q  <= read_trigger_d;
      changed_q       <= changed_d;
    end
  end

  // Reads return the pre-side-effect value; side effects show up next cycle.
  assign bit_field_if.value     = value_q;
  assign bit_field_if.read_data = value_q;
  assign o_value                = value_q;
  assign o_write_trigger        = write_trigger_q;
  assign o_read_trigger         = read_trigger_q;
  assign o_changed              = changed_q;

endmodule

// File: doc/rggen_bit_field_rw_action.md
Name: rggen_bit_field_rw_action

Overview:
- Generalised single-field register bit-field engine, the parametrised successor of the fixed write/read-set field.
- Software read side effect and write action are each chosen by parameter.
- Adds per-bit hardware set/clear inputs, registered software access trigger pulses, and a registered value-change flag.
- Instantiated once per bit field inside generated register blocks. Connects to the register through the bit_field_if (bit_field modport).

Parameters:
- WIDTH, 8, field width in bits (1..64).
- INITIAL_VALUE, '0, WIDTH-bit value loaded on reset.
- READ_ACTION, 0, software read side effect: 0 none, 1 clear all bits, 2 set all bits.
- WRITE_ACTION, 0, software write action: 0 masked write, 1 W1C, 2 W1S, 3 W0C, 4 W0S, 5 WC (any write clears), 6 WS (any write sets), 7 read-only (writes ignored).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- bit_field_if  interface  -  rggen_bit_field_if.bit_field; uses valid, read_mask, write_mask, write_data; drives value, read_data.
- i_hw_set  input  WIDTH  per-bit hardware set request, sampled each clock.
- i_hw_clear  input  WIDTH  per-bit hardware clear request, sampled each clock.
- o_value  output  WIDTH  current field value.
- o_write_trigger  output  WIDTH  registered per-bit write-strobe pulse.
- o_read_trigger  output  1  registered read pulse.
- o_changed  output  1  registered flag, high one cycle after any field bit changed.

Behaviour:
- Clock and reset: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset values: value = INITIAL_VALUE; o_write_trigger = 0; o_read_trigger = 0; o_changed = 0. Reset asserted mid-operation overrides everything immediately.
- Access decode:
  - read access = valid && (read_mask != 0).
  - write access = valid && (read_mask == 0).
  - A write access with write_mask == 0 is legal. It changes nothing and produces an all-zero write trigger.
- Output data: bit_field_if.value = bit_field_if.read_data = o_value = stored value. The read returns the pre-side-effect value, so side effects become visible the next cycle.
- Software next value (sw_next), per bit, with m = write_mask, d = write_data, v = current value:
  - read access, READ_ACTION 0: v.
  - read access, READ_ACTION 1: 0.
  - read access, READ_ACTION 2: 1.
  - write access, WRITE_ACTION 0: (d&m) | (v&~m).
  - write access, WRITE_ACTION 1: v & ~(d&m).
  - write access, WRITE_ACTION 2: v | (d&m).
  - write access, WRITE_ACTION 3: v & ~(~d&m).
  - write access, WRITE_ACTION 4: v | (~d&m).
  - write access, WRITE_ACTION 5: v & ~m.
  - write access, WRITE_ACTION 6: v | m.
  - write access, WRITE_ACTION 7: v.
  - no access: v.
- Hardware merge, per bit, same cycle: next = (sw_next & ~i_hw_clear) | i_hw_set.
  - Hardware set beats hardware clear.
  - Hardware beats software, so a sticky event is never lost to a simultaneous software W1C or read-clear.
- Value update: registered on every rising edge; no enable beyond the above.
- o_write_trigger: registered. Next value = write_mask on a write access, otherwise 0. Pulses exactly one cycle after the access, including for WRITE_ACTION 7.
- o_read_trigger: registered. Next value = 1 on a read access, otherwise 0.
- o_changed: registered. Next value = (next != v). Goes high in the same cycle the new value appears on o_value, and only for that cycle unless the value changes again.
- Back-to-back accesses on consecutive cycles: each access is processed independently; triggers produce consecutive pulses.
- Illegal parameter values (READ_ACTION > 2): flagged by an elaboration-time $error.

Test Plan:
- Reset, INITIAL_VALUE=8'hA5 -> o_value=8'hA5, all triggers 0, o_changed 0; reassert reset after writing 8'h00 -> o_value returns to 8'hA5 asynchronously.
- READ_ACTION=2, WRITE_ACTION=0, value 8'h00:
  - read -> read_data=8'h00 that cycle; o_value=8'hFF next cycle; o_read_trigger and o_changed pulse once.
  - second read -> o_changed stays 0.
- WRITE_ACTION=1, value 8'hF0:
  - write d=8'h30, m=8'hFF -> 8'hC0, o_write_trigger=8'hFF for one cycle.
  - write with m=8'h00 -> value unchanged, trigger 8'h00, o_changed 0.
- WRITE_ACTION=1, value 8'h01: W1C with d=8'h01 and i_hw_set=8'h01 in the same cycle -> value stays 8'h01, o_changed 0.
- READ_ACTION=1, value 8'h0F: i_hw_clear=8'h03 and i_hw_set=8'h03 with no access -> value 8'h0F; next, a read with i_hw_set=8'h80 -> read_data=8'h0F, then value 8'h80.
- WRITE_ACTION=0: writes d=8'h12, 8'h34, 8'h56 on consecutive cycles with masks 8'hFF, 8'h0F, 8'hF0 -> values 8'h12, 8'h14, 8'h54; three consecutive trigger pulses.
